// File: rtl/multi_debouncer.sv
// Multi-channel push-button conditioner.
// Each channel runs a flop synchroniser, a symmetric stability counter that gates
// changes of the debounced level, and registered single-cycle press/release pulses.
module multi_debouncer #(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      CNT_W       = 24,
  parameter logic [CNT_W-1:0] STABLE_CNT  = 24'hFF_FFFF
) (
  input  logic              i_clk25,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_btn_raw,
  output logic [NUM_CH-1:0] o_btn_level,
  output logic [NUM_CH-1:0] o_btn_press,
  output logic [NUM_CH-1:0] o_btn_release
);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  // Count value on which a persistent mismatch is accepted as the new level.
  localparam logic [CNT_W-1:0] LastCnt = STABLE_CNT - CntOne;

  logic [SYNC_STAGES-1:0] r_sync    [NUM_CH];
  logic [CNT_W-1:0]       r_cnt     [NUM_CH];
  logic [CNT_W-1:0]       w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]      w_sync_out;
  logic [NUM_CH-1:0]      w_level_nxt;
  logic [NUM_CH-1:0]      r_level;
  logic [NUM_CH-1:0]      r_press;
  logic [NUM_CH-1:0]      r_release;

  // Shift raw inputs through the synchroniser chain; bit 0 is the capture flop.
  always_ff @(posedge i_clk25) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_rst) begin
        r_sync[i] <= '0;
      end else begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], i_btn_raw[i]};
      end
    end
  end

  // Tap the last synchroniser stage of each channel.
  always_comb begin
    w_sync_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sync_out[i] = r_sync[i][SYNC_STAGES-1];
    end
  end

  // Stability counting: any matching cycle clears the count, so only an unbroken
  // run of STABLE_CNT mismatching cycles moves the level. Clearing on the level
  // change keeps the counter from ever passing LastCnt.
  always_comb begin
    w_level_nxt = r_level;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_sync_out[i] != r_level[i]) begin
        if (r_cnt[i] == LastCnt) begin
          w_level_nxt[i] = w_sync_out[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CntOne;
        end
      end
    end
  end

  // Register counters, level and edge pulses. r_level is the delayed level relative
  // to w_level_nxt, so the pulses land on the first cycle of the new level.
  always_ff @(posedge i_clk25) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_level   <= w_level_nxt;
      r_press   <= w_level_nxt & ~r_level;
      r_release <= ~w_level_nxt & r_level;
    end
  end

  assign o_btn_level   = r_level;
  assign o_btn_press   = r_press;
  assign o_btn_release = r_release;

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: stimulus pushes expected pulse events,
// a negedge monitor pops and checks them whenever the DUT emits a pulse.
module tb_multi_debouncer;

  localparam int unsigned NCH = 4;
  localparam int          LAT = 6;  // SYNC_STAGES + STABLE_CNT

  typedef struct {
    int             cyc;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] prs;
    logic [NCH-1:0] rel;
  } ev_t;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] raw;
  logic [NCH-1:0] level;
  logic [NCH-1:0] press;
  logic [NCH-1:0] release_p;
  logic [NCH-1:0] prev_level;

  int  cyc;
  int  checks;
  int  errors;
  ev_t q[$];

  multi_debouncer #(
    .NUM_CH     (NCH),
    .SYNC_STAGES(2),
    .CNT_W      (3),
    .STABLE_CNT (3'd4)
  ) dut (
    .i_clk25      (clk),
    .i_rst        (rst),
    .i_btn_raw    (raw),
    .o_btn_level  (level),
    .o_btn_press  (press),
    .o_btn_release(release_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input int at, input logic [NCH-1:0] l, input logic [NCH-1:0] p,
                         input logic [NCH-1:0] r);
    ev_t e;
    e.cyc = at;
    e.lvl = l;
    e.prs = p;
    e.rel = r;
    q.push_back(e);
  endtask

  task automatic check_quiet(input string name, input logic [NCH-1:0] lmask);
    checks++;
    if (((level & lmask) !== '0) || (press !== '0) || (release_p !== '0)) begin
      errors++;
      $display("FAIL %s: level=%b press=%b release=%b, required level&%b=0 and no pulses",
               name, level, press, release_p, lmask);
    end
  endtask

  // Monitor: pulse/level relation every cycle, scoreboard pop on each pulse.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      checks++;
      if ((press !== (level & ~prev_level)) || (release_p !== (~level & prev_level))) begin
        errors++;
        $display("FAIL pulse_vs_level cyc=%0d: press=%b release=%b level=%b prev=%b",
                 cyc, press, release_p, level, prev_level);
      end
      if ((|press) || (|release_p)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d: press=%b release=%b, required none",
                   cyc, press, release_p);
        end else begin
          e = q.pop_front();
          if ((cyc < e.cyc - 1) || (cyc > e.cyc + 1)) begin
            errors++;
            $display("FAIL event_time: cyc=%0d, required %0d +/-1", cyc, e.cyc);
          end
          checks++;
          if (level !== e.lvl) begin
            errors++;
            $display("FAIL event_level: %b, required %b", level, e.lvl);
          end
          checks++;
          if (press !== e.prs) begin
            errors++;
            $display("FAIL event_press: %b, required %b", press, e.prs);
          end
          checks++;
          if (release_p !== e.rel) begin
            errors++;
            $display("FAIL event_release: %b, required %b", release_p, e.rel);
          end
        end
      end
    end
    prev_level = level;
  end

  initial begin
    logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    checks     = 0;
    errors     = 0;
    prev_level = '0;

    // 1. Reset with all buttons pressed.
    rst = 1'b1;
    raw = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_quiet("reset_hold", 4'hF);
    end
    rst = 1'b0;
    raw = 4'h0;
    tick(1);
    check_quiet("reset_first_cycle", 4'hF);

    // 2. Clean press on ch0.
    raw[0] = 1'b1;
    push_ev(cyc + LAT, 4'b0001, 4'b0001, 4'b0000);
    tick(10);

    // 3a. Three-cycle glitch on ch1 is rejected.
    raw[1] = 1'b1;
    tick(3);
    raw[1] = 1'b0;
    tick(10);
    check_quiet("glitch_ch1", 4'b0010);

    // 3b. Bounce, then hold: level rises only after four consecutive ones.
    for (int j = 0; j < 9; j++) begin
      raw[1] = pat[j];
      if (j == 5) push_ev(cyc + LAT, 4'b0011, 4'b0010, 4'b0000);
      tick(1);
    end
    tick(10);

    // 4. Release ch0.
    raw[0] = 1'b0;
    push_ev(cyc + LAT, 4'b0010, 4'b0000, 4'b0001);
    tick(10);

    // Release ch1 to get back to idle.
    raw[1] = 1'b0;
    push_ev(cyc + LAT, 4'b0000, 4'b0000, 4'b0010);
    tick(10);

    // 5. Simultaneous press and release on ch1 and ch3.
    raw = 4'b1010;
    push_ev(cyc + LAT, 4'b1010, 4'b1010, 4'b0000);
    tick(10);
    raw = 4'b0000;
    push_ev(cyc + LAT, 4'b0000, 4'b0000, 4'b1010);
    tick(10);

    // 6. Reset during an in-progress debounce of ch2.
    raw[2] = 1'b1;
    tick(4);
    check_quiet("pre_reset_no_early", 4'b0100);
    rst = 1'b1;
    tick(1);
    check_quiet("mid_reset", 4'b0100);
    tick(1);
    check_quiet("mid_reset_end", 4'b0100);
    rst = 1'b0;
    push_ev(cyc + LAT, 4'b0100, 4'b0100, 4'b0000);
    tick(10);
    raw[2] = 1'b0;
    push_ev(cyc + LAT, 4'b0000, 4'b0000, 4'b0100);
    tick(10);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d pending, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
